// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, functs,
// ALU codes, mux encodings, FSM states and trap causes.
package mips_ctrl_pkg;

    localparam int MEM_TIMEOUT_DEFAULT = 255;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RESULT = 2'b11;

    localparam logic [1:0] RES_DMEM = 2'b00;
    localparam logic [1:0] RES_ALU  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] WA_RT  = 2'b00;
    localparam logic [1:0] WA_RD  = 2'b01;
    localparam logic [1:0] WA_R31 = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps opcode/funct to the ALU operation and flags anything outside the
// supported instruction set as illegal.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_JR:   alu_ctrl = ALU_ADD;
                    default: illegal  = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI, OP_J, OP_JAL: alu_ctrl = ALU_ADD;
            OP_BEQ:  alu_ctrl = ALU_SUB;
            default: illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS sequencer: steps each instruction through FETCH..WB,
// handshakes with slow memories and traps on illegal opcodes or timeouts.
module mips_mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        sel_alu_b,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  sel_pc,
    output logic [1:0]  sel_result,
    output logic [1:0]  sel_wa,
    output logic [3:0]  alu_ctrl,
    output logic        instr_done,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic [1:0] cause_q, next_cause;
    logic [3:0] dec_alu;
    logic       dec_illegal;

    logic [5:0] opcode, funct;
    logic       is_rtype, is_jr, is_lw, is_sw, is_beq, is_addi, is_jump, is_jal;
    logic       timeout_hit;

    assign opcode   = instruction[31:26];
    assign funct    = instruction[5:0];
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jump  = (opcode == OP_J) || is_jal;

    // This cycle would be the MEM_TIMEOUT-th wait without a response.
    assign timeout_hit = (wait_cnt == 8'(MEM_TIMEOUT - 1));

    mips_alu_decoder u_alu_decoder (
        .opcode   (opcode),
        .funct    (funct),
        .alu_ctrl (dec_alu),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= 8'd0;
            else if (state == FETCH || state == MEM)
                wait_cnt <= wait_cnt + 8'd1;
            if (next_state == TRAP && state != TRAP)
                cause_q <= next_cause;
        end
    end

    always_comb begin
        next_state = state;
        next_cause = cause_q;
        case (state)
            IDLE:   next_state = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    next_state = DECODE;
                end else if (timeout_hit) begin
                    next_state = TRAP;
                    next_cause = CAUSE_IMEM;
                end
            end
            DECODE: begin
                if (dec_illegal) begin
                    next_state = TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end else if (is_jump) begin
                    next_state = FETCH;
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (is_beq || is_jr)
                    next_state = FETCH;
                else if (is_lw || is_sw)
                    next_state = MEM;
                else
                    next_state = WB;
            end
            MEM: begin
                if (dmem_ack) begin
                    next_state = FETCH;
                end else if (timeout_hit) begin
                    next_state = TRAP;
                    next_cause = CAUSE_DMEM;
                end
            end
            WB:      next_state = FETCH;
            TRAP:    next_state = TRAP;
            default: next_state = IDLE;
        endcase
    end

    // EXEC, MEM and WB share the same ALU setup so operands stay valid.
    always_comb begin
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        sel_alu_b  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        sel_pc     = PC_PLUS4;
        sel_result = RES_DMEM;
        sel_wa     = WA_RT;
        alu_ctrl   = ALU_AND;
        instr_done = 1'b0;
        trap       = (state == TRAP);
        trap_cause = cause_q;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            DECODE: begin
                if (!dec_illegal && is_jump) begin
                    sel_pc     = PC_JUMP;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    if (is_jal) begin
                        rf_we      = 1'b1;
                        sel_wa     = WA_R31;
                        sel_result = RES_PC4;
                    end
                end
            end
            EXEC: begin
                alu_ctrl  = dec_alu;
                sel_alu_b = is_lw || is_sw || is_addi;
                if (is_beq) begin
                    pc_we      = 1'b1;
                    sel_pc     = zero ? PC_BRANCH : PC_PLUS4;
                    instr_done = 1'b1;
                end else if (is_jr) begin
                    sel_result = RES_ALU;
                    sel_pc     = PC_RESULT;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
            end
            MEM: begin
                alu_ctrl  = dec_alu;
                sel_alu_b = 1'b1;
                dmem_req  = 1'b1;
                dmem_we   = is_sw;
                if (dmem_ack) begin
                    rf_we      = is_lw;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
            end
            WB: begin
                alu_ctrl   = dec_alu;
                sel_alu_b  = is_addi;
                rf_we      = 1'b1;
                sel_result = RES_ALU;
                sel_wa     = is_rtype ? WA_RD : WA_RT;
                pc_we      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: walks hand-timed instruction
// sequences and compares every output against hand-written vectors.
module tb_mips_mc_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ack = 1'b0;

    logic        imem_req, ir_we, pc_we, rf_we, sel_alu_b, dmem_req, dmem_we;
    logic [1:0]  sel_pc, sel_result, sel_wa;
    logic [3:0]  alu_ctrl;
    logic        instr_done, trap;
    logic [1:0]  trap_cause;
    logic [20:0] outs;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    mips_mc_controller #(.MEM_TIMEOUT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .zero        (zero),
        .imem_ready  (imem_ready),
        .dmem_ack    (dmem_ack),
        .imem_req    (imem_req),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .rf_we       (rf_we),
        .sel_alu_b   (sel_alu_b),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .sel_pc      (sel_pc),
        .sel_result  (sel_result),
        .sel_wa      (sel_wa),
        .alu_ctrl    (alu_ctrl),
        .instr_done  (instr_done),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    assign outs = {imem_req, ir_we, pc_we, rf_we, sel_alu_b, dmem_req, dmem_we,
                   sel_pc, sel_result, sel_wa, alu_ctrl, instr_done, trap, trap_cause};

    // Strobes are {imem_req, ir_we, pc_we, rf_we, sel_alu_b, dmem_req, dmem_we}.
    function automatic logic [20:0] ov(input logic [6:0] strobes, input logic [1:0] pc,
                                       input logic [1:0] res, input logic [1:0] wa,
                                       input logic [3:0] alu, input logic done,
                                       input logic trp, input logic [1:0] cause);
        return {strobes, pc, res, wa, alu, done, trp, cause};
    endfunction

    task automatic checkOutput(input string tag, input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic ready,
                                 input logic ack, input logic z);
        instruction = instr;
        imem_ready  = ready;
        dmem_ack    = ack;
        zero        = z;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic stepCheck(input string tag, input logic [31:0] instr, input logic ready,
                             input logic ack, input logic z, input logic [20:0] exp);
        tick();
        applyStimulus(instr, ready, ack, z);
        #1;
        checkOutput(tag, outs, exp);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("idle_after_reset", outs, 21'd0);
    endtask

    localparam logic [20:0] F_RDY  = ov(7'b1100000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00);
    localparam logic [20:0] F_WAIT = ov(7'b1000000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00);
    localparam logic [20:0] NONE   = 21'd0;

    initial begin
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("reset_state", outs, NONE);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("idle", outs, NONE);

        // add $3,$1,$2 with zero-wait fetch
        stepCheck("add_fetch", 32'h00221820, 1'b1, 1'b0, 1'b0, F_RDY);
        stepCheck("add_decode", 32'h00221820, 1'b0, 1'b0, 1'b0, NONE);
        stepCheck("add_exec", 32'h00221820, 1'b0, 1'b0, 1'b0,
                  ov(7'b0000000, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 2'b00));
        stepCheck("add_wb", 32'h00221820, 1'b0, 1'b0, 1'b0,
                  ov(7'b0011000, 2'b00, 2'b01, 2'b01, 4'b0010, 1'b1, 1'b0, 2'b00));

        // lw $2,4($1) with three data wait cycles
        stepCheck("lw_fetch", 32'h8C220004, 1'b1, 1'b0, 1'b0, F_RDY);
        stepCheck("lw_decode", 32'h8C220004, 1'b0, 1'b0, 1'b0, NONE);
        stepCheck("lw_exec", 32'h8C220004, 1'b0, 1'b0, 1'b0,
                  ov(7'b0000100, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < 3; i++)
            stepCheck("lw_mem_wait", 32'h8C220004, 1'b0, 1'b0, 1'b0,
                      ov(7'b0000110, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 2'b00));
        stepCheck("lw_mem_ack", 32'h8C220004, 1'b0, 1'b1, 1'b0,
                  ov(7'b0011110, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b1, 1'b0, 2'b00));

        // beq taken then not taken
        stepCheck("beq1_fetch", 32'h10220003, 1'b1, 1'b0, 1'b1, F_RDY);
        stepCheck("beq1_decode", 32'h10220003, 1'b0, 1'b0, 1'b1, NONE);
        stepCheck("beq_taken", 32'h10220003, 1'b0, 1'b0, 1'b1,
                  ov(7'b0010000, 2'b01, 2'b00, 2'b00, 4'b0110, 1'b1, 1'b0, 2'b00));
        stepCheck("beq0_fetch", 32'h10220003, 1'b1, 1'b0, 1'b0, F_RDY);
        stepCheck("beq0_decode", 32'h10220003, 1'b0, 1'b0, 1'b0, NONE);
        stepCheck("beq_not_taken", 32'h10220003, 1'b0, 1'b0, 1'b0,
                  ov(7'b0010000, 2'b00, 2'b00, 2'b00, 4'b0110, 1'b1, 1'b0, 2'b00));

        // jal then jr $31
        stepCheck("jal_fetch", 32'h0C000010, 1'b1, 1'b0, 1'b0, F_RDY);
        stepCheck("jal_decode", 32'h0C000010, 1'b0, 1'b0, 1'b0,
                  ov(7'b0011000, 2'b10, 2'b10, 2'b10, 4'b0000, 1'b1, 1'b0, 2'b00));
        stepCheck("jr_fetch", 32'h03E00008, 1'b1, 1'b0, 1'b0, F_RDY);
        stepCheck("jr_decode", 32'h03E00008, 1'b0, 1'b0, 1'b0, NONE);
        stepCheck("jr_exec", 32'h03E00008, 1'b0, 1'b0, 1'b0,
                  ov(7'b0010000, 2'b11, 2'b01, 2'b00, 4'b0010, 1'b1, 1'b0, 2'b00));

        // sw interrupted by reset while waiting in MEM
        stepCheck("sw_fetch", 32'hAC220004, 1'b1, 1'b0, 1'b0, F_RDY);
        stepCheck("sw_decode", 32'hAC220004, 1'b0, 1'b0, 1'b0, NONE);
        stepCheck("sw_exec", 32'hAC220004, 1'b0, 1'b0, 1'b0,
                  ov(7'b0000100, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 2'b00));
        stepCheck("sw_mem", 32'hAC220004, 1'b0, 1'b0, 1'b0,
                  ov(7'b0000111, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 2'b00));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("sw_async_reset", outs, NONE);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("idle_after_sw_reset", outs, NONE);
        stepCheck("fetch_after_reset", 32'hAC220004, 1'b0, 1'b0, 1'b0, F_WAIT);

        // illegal opcode 0x3F traps with cause 01 and stays there
        stepCheck("ill_fetch", 32'hFC000000, 1'b1, 1'b0, 1'b0, F_RDY);
        stepCheck("ill_decode", 32'hFC000000, 1'b1, 1'b1, 1'b1, NONE);
        for (int i = 0; i < 3; i++)
            stepCheck("ill_trap", 32'hFC000000, 1'b1, 1'b1, 1'b1,
                      ov(7'b0000000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 2'b01));

        // R-type with unsupported funct is also illegal
        doReset();
        stepCheck("fn_fetch", 32'h0000003F, 1'b1, 1'b0, 1'b0, F_RDY);
        stepCheck("fn_decode", 32'h0000003F, 1'b0, 1'b0, 1'b0, NONE);
        stepCheck("fn_trap", 32'h0000003F, 1'b0, 1'b0, 1'b0,
                  ov(7'b0000000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 2'b01));

        // instruction memory never answers
        doReset();
        for (int i = 0; i < 4; i++)
            stepCheck("imem_wait", 32'h0, 1'b0, 1'b0, 1'b0, F_WAIT);
        tick();
        stepCheck("imem_timeout", 32'h0, 1'b0, 1'b0, 1'b0,
                  ov(7'b0000000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 2'b10));

        // data memory never acknowledges a store
        doReset();
        stepCheck("swto_fetch", 32'hAC220004, 1'b1, 1'b0, 1'b0, F_RDY);
        stepCheck("swto_decode", 32'hAC220004, 1'b0, 1'b0, 1'b0, NONE);
        stepCheck("swto_exec", 32'hAC220004, 1'b0, 1'b0, 1'b0,
                  ov(7'b0000100, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 2'b00));
        stepCheck("swto_mem", 32'hAC220004, 1'b0, 1'b0, 1'b0,
                  ov(7'b0000111, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < 4; i++)
            tick();
        stepCheck("dmem_timeout", 32'hAC220004, 1'b0, 1'b0, 1'b0,
                  ov(7'b0000000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 2'b11));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle sequencer for the MIPS datapath: drives every datapath select and write enable, and handshakes with instruction and data memories that take one or more cycles to respond. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, advances the PC exactly once per instruction, and traps on illegal opcodes or memory timeouts. It sits beside the datapath and replaces the single-cycle combinational control unit; the PC register gains an enable (`pc_we`) and an instruction register gains a load (`ir_we`).

## Interface
- `MEM_TIMEOUT`, 255: maximum wait cycles for `imem_ready`/`dmem_ack`; 1..255.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces state IDLE.
- `instruction` in 32: IR output; stable from DECODE through end of instruction.
- `zero` in 1: ALU zero flag.
- `imem_ready` in 1: fetch data valid on `instruction` source this cycle.
- `dmem_ack` in 1: data access complete; for loads, `rd` is valid this cycle.
- `imem_req`, `ir_we`, `pc_we`, `rf_we`, `sel_alu_b`, `dmem_req`, `dmem_we` out 1: datapath and memory strobes.
- `sel_pc`, `sel_result`, `sel_wa` out 2: datapath mux selects.
- `alu_ctrl` out 4: ALU operation.
- `instr_done` out 1: one-cycle pulse in the instruction's final cycle, which is also the cycle where `pc_we` = 1.
- `trap` out 1: high while in TRAP.
- `trap_cause` out 2: 01 illegal, 10 imem timeout, 11 dmem timeout. Held in TRAP.

## Operation
- Encodings:
  - `sel_pc`: 00 pc+4, 01 branch, 10 jump, 11 result.
  - `sel_result`: 00 dmem rd, 01 alu_out, 10 pc+4.
  - `sel_wa`: 00 rt, 01 rd, 10 r31.
  - `alu_ctrl`: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- Supported instructions:
  - R-type (op 00), funct: add 20, sub 22, and 24, or 25, slt 2A, jr 08.
  - lw 23, sw 2B, beq 04, addi 08, j 02, jal 03.
  - Anything else is illegal.
- All outputs are 0 unless listed below. Outputs are a combinational decode of state plus `instruction`/`zero`/handshake inputs.
- IDLE: all outputs 0. Go to FETCH next cycle.
- FETCH:
  - Assert `imem_req`.
  - On `imem_ready`: `ir_we`=1, go to DECODE.
  - Otherwise increment the wait counter; on reaching MEM_TIMEOUT, go to TRAP with cause 10.
- DECODE:
  - Illegal opcode: go to TRAP with cause 01.
  - j: `sel_pc`=10, `pc_we`=1, `instr_done`; go to FETCH.
  - jal: same as j, plus `rf_we`=1, `sel_wa`=10, `sel_result`=10.
  - Everything else: go to EXEC.
- EXEC:
  - R-ALU: `sel_alu_b`=0, `alu_ctrl` from funct; go to WB.
  - addi: `sel_alu_b`=1, ADD; go to WB.
  - lw/sw: `sel_alu_b`=1, ADD; go to MEM.
  - beq: `sel_alu_b`=0, SUB, `pc_we`=1, `sel_pc` = `zero` ? 01 : 00, `instr_done`; go to FETCH.
  - jr: ADD, `sel_alu_b`=0 (rt=$0), `sel_result`=01, `sel_pc`=11, `pc_we`=1, `instr_done`; go to FETCH.
- MEM:
  - Hold the EXEC ALU controls; `dmem_req`=1; `dmem_we`=1 for sw.
  - On `dmem_ack` for lw: `rf_we`=1, `sel_result`=00, `sel_wa`=00.
  - On `dmem_ack` for either: `pc_we`=1, `sel_pc`=00, `instr_done`; go to FETCH.
  - Timeout: go to TRAP with cause 11.
- WB:
  - Hold the EXEC ALU controls; `rf_we`=1, `sel_result`=01, `sel_wa` = R-type ? 01 : 00.
  - `pc_we`=1, `sel_pc`=00, `instr_done`; go to FETCH.
- TRAP: all strobes 0, `trap`=1. Exit only by `reset`.

## Timing
- Reset values: state IDLE, every output 0, wait counter 0, `trap_cause` 00.
- First `imem_req` appears one cycle after `reset` deasserts.
- Cycles per instruction with zero-wait memory (ready/ack in the first request cycle): j/jal 2, beq/jr 3, R/addi/lw/sw 4. Each wait cycle adds 1.
- Wait counter: 8 bits, cleared on every state entry. If ready/ack and timeout coincide, ready/ack wins.
- `imem_req`/`dmem_req` stay high continuously until the ack cycle inclusive. The memory samples the request on any cycle it is high.
- The PC changes only at the `pc_we` edge, so the datapath's pc+4 and branch target are computed from the current instruction's PC throughout.
- Reset mid-instruction: outputs drop to 0 asynchronously; no partial `rf_we`/`pc_we` edge is taken after `reset` rises.
- The illegal check runs in DECODE only. Illegal funct in an R-type is also cause 01.

## Structure
- Package `mips_ctrl_pkg`: opcode and funct constants, `alu_ctrl` codes, sel encodings, state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP), trap-cause codes, default for `MEM_TIMEOUT`.
- Sub-module `mips_alu_decoder`: combinational map from opcode/funct to `alu_ctrl`, plus an `illegal` flag.
- Top level: state register, wait counter, cause register, output decode.

## Test plan
- Zero-wait `add $3,$1,$2` (0x00221820) → `imem_req`, `ir_we` at cycle 1; WB at cycle 4 with `rf_we`=1, `sel_wa`=01, `sel_result`=01, `alu_ctrl`=0010, `pc_we`=1, `instr_done`=1.
- `lw $2,4($1)` (0x8C220004), `dmem_ack` delayed 3 cycles → `dmem_req` high for 4 cycles; at ack `rf_we`=1, `sel_result`=00, `pc_we`=1; total 7 cycles.
- `beq` (0x10220003) with `zero`=1 then `zero`=0 → EXEC `sel_pc`=01 then 00, `alu_ctrl`=0110, 3 cycles each, `rf_we` never 1.
- `jal` (0x0C000010) → DECODE: `sel_pc`=10, `sel_wa`=10, `sel_result`=10, `rf_we`=1, `pc_we`=1. `jr $31` (0x03E00008) → EXEC: `sel_pc`=11, `pc_we`=1.
- Opcode 0x3F, or `imem_ready` held low with MEM_TIMEOUT=4 → TRAP with `trap_cause` 01 or 10 respectively; every strobe stays 0 until `reset`.
- `reset` pulsed during MEM of sw → `dmem_req`/`dmem_we` fall immediately; next `imem_req` appears one cycle after deassert.
